// File: rtl/game_pkg.sv
// Shared phase encoding and datapath widths for the game event sequencer.
// Phase codes match the ones decoded by the game-phase selector.
package game_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t ST_IDLE      = 2'b00;
  localparam phase_t ST_COUNTDOWN = 2'b01;
  localparam phase_t ST_PLAY      = 2'b10;
  localparam phase_t ST_DONE      = 2'b11;

  localparam int COUNT_W = 4;
  localparam int TIME_W  = 8;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: emits a single-cycle tick every TICKS_PER_SEC clocks.
// clr restarts the count so the next second is a full TICKS_PER_SEC cycles.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICKS_PER_SEC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/game_event_sequencer.sv
// IDLE -> COUNTDOWN -> PLAY -> DONE sequencer driving game-phase events and displays.
// Define GAME_ABORT_EN to let start_btn abort COUNTDOWN/PLAY back to IDLE.
module game_event_sequencer
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int COUNT_SECS    = 3,
  parameter int GAME_SECS     = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               stop_evt,
  output logic               countdown_start,
  output logic               game_start,
  output logic               game_finish,
  output logic [COUNT_W-1:0] count_value,
  output logic [TIME_W-1:0]  time_left,
  output logic               busy
);

`ifdef GAME_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  phase_t             state, state_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic [TIME_W-1:0]  time_nxt;
  logic               tick;
  logic               clr;

  // Any phase change restarts the prescaler so each phase begins with a full second.
  assign clr = (state_nxt != state);

  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count_value;
    time_nxt  = time_left;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_btn) begin
          state_nxt = ST_COUNTDOWN;
          count_nxt = COUNT_SECS[COUNT_W-1:0];
          time_nxt  = '0;
        end
      end
      ST_COUNTDOWN: begin
        if (ABORT_EN && start_btn) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
          time_nxt  = '0;
        end else if (tick) begin
          if (count_value == COUNT_W'(1)) begin
            state_nxt = ST_PLAY;
            count_nxt = '0;
            time_nxt  = GAME_SECS[TIME_W-1:0];
          end else begin
            count_nxt = count_value - COUNT_W'(1);
          end
        end
      end
      default: begin
        // stop_evt takes priority over a coincident tick, freezing time_left.
        if (ABORT_EN && start_btn) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
          time_nxt  = '0;
        end else if (stop_evt) begin
          state_nxt = ST_DONE;
        end else if (tick) begin
          if (time_left == TIME_W'(1)) begin
            state_nxt = ST_DONE;
            time_nxt  = '0;
          end else begin
            time_nxt = time_left - TIME_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      count_value     <= '0;
      time_left       <= '0;
      countdown_start <= 1'b0;
      game_start      <= 1'b0;
      game_finish     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nxt;
      count_value     <= count_nxt;
      time_left       <= time_nxt;
      countdown_start <= (state_nxt == ST_COUNTDOWN);
      game_start      <= (state_nxt == ST_PLAY);
      game_finish     <= (state_nxt == ST_DONE);
      busy            <= (state_nxt == ST_COUNTDOWN) || (state_nxt == ST_PLAY);
    end
  end

endmodule
